divider_unit: RTL and testbench

Multi-cycle unsigned restoring divider for the CPU's HI/LO datapath, the inverse of the shift-add multiplier. It is launched by the ALU control code for DIVU. It computes a WIDTH-bit quotient and remainder in a fixed number of cycles, one quotient bit per clock. It presents both as a single 2*WIDTH result with remainder in HI and quotient in LO.

---
 rtl/divider_unit.sv | 106 ++++++++++
 tb/tb_divider_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Multi-cycle unsigned restoring divider (DIVU) for the HI/LO datapath.
// One quotient bit per clock; result is {remainder, quotient}, WIDTH cycles after launch.
module divider_unit #(
   parameter int unsigned WIDTH = 32,
   parameter logic [5:0]  DIVU  = 6'b011011
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Signal,
   input  logic [WIDTH-1:0]   dataA,
   input  logic [WIDTH-1:0]   dataB,
   output logic [2*WIDTH-1:0] dataOut,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [5:0]           r_sig_q;
   logic [WIDTH-1:0]     r_div;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [CW-1:0]        r_count;
   logic                 r_dz;
   logic [2*WIDTH-1:0]   r_data_out;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dz_out;

   logic                 w_launch;
   logic [WIDTH:0]       w_trial;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [WIDTH-1:0]     w_quo_nxt;

   assign w_launch = (Signal == DIVU) && (r_sig_q != DIVU);

   // The partial remainder is always below D after a step, so WIDTH bits hold it;
   // the extra bit needed for the trial subtraction exists only in w_trial.
   assign w_trial   = {r_rem, r_quo[WIDTH-1]};
   assign w_ge      = (w_trial >= {1'b0, r_div});
   assign w_rem_nxt = w_ge ? WIDTH'(w_trial - {1'b0, r_div}) : w_trial[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_launch ? S_RUN : S_IDLE;
         S_RUN:   w_state_nxt = (r_count == LAST) ? S_DONE : S_RUN;
         S_DONE:  w_state_nxt = w_launch ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sig_q    <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_count    <= '0;
         r_dz       <= 1'b0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dz_out   <= 1'b0;
      end else begin
         r_sig_q <= Signal;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_DONE);
         if (r_state != S_RUN) begin
            if (w_launch) begin
               r_div   <= dataB;
               r_quo   <= dataA;
               r_rem   <= '0;
               r_count <= '0;
               r_dz    <= (dataB == '0);
            end
         end else begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + CW'(1);
            if (r_count == LAST) begin
               r_data_out <= {w_rem_nxt, w_quo_nxt};
               r_dz_out   <= r_dz;
            end
         end
      end
   end

   assign dataOut     = r_data_out;
   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dz_out;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed test-plan steps plus random
// operands, checked against plain '/' and '%' arithmetic.
module tb_divider_unit;

   localparam logic [5:0] DIVU = 6'b011011;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  Signal;
   logic [31:0] dataA, dataB;
   logic [63:0] dataOut;
   logic        busy, done, div_by_zero;

   int n_checks = 0;
   int n_err    = 0;

   divider_unit #(.WIDTH(32), .DIVU(DIVU)) dut (
      .clk(clk), .reset(reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
      .dataOut(dataOut), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch a/b, watch up to 40 edges, and check latency, busy span, result and flag.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         input bit stop_at_done, input int reraise, input string tag);
      logic [63:0] exp_res;
      logic [63:0] got;
      logic        gdz;
      int          lat, bcnt, nd;
      exp_res = ref_div(a, b);
      got = '0; gdz = 1'b0; lat = -1; bcnt = 0; nd = 0;
      Signal = DIVU; dataA = a; dataB = b;
      tick();
      if (!hold) Signal = 6'd0;
      dataA = $urandom; dataB = $urandom;
      for (int c = 0; c < 40; c++) begin
         if (reraise != 0 && c == reraise) begin
            Signal = DIVU; dataA = $urandom; dataB = $urandom;
         end
         if (reraise != 0 && c == reraise + 2) Signal = 6'd0;
         if (busy) bcnt++;
         tick();
         if (done) begin
            nd++;
            if (lat < 0) begin
               lat = c + 1; got = dataOut; gdz = div_by_zero;
            end
         end
         if (stop_at_done && done) break;
      end
      check({tag, ".latency"}, 64'(lat), 64'd32);
      check({tag, ".busy_cycles"}, 64'(bcnt), 64'd32);
      check({tag, ".dataOut"}, got, exp_res);
      check({tag, ".div_by_zero"}, 64'(gdz), 64'(b == 32'd0));
      if (!stop_at_done) check({tag, ".done_pulses"}, 64'(nd), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int nd;
      logic [31:0] ra, rb;
      reset = 1'b1; Signal = 6'd0; dataA = '0; dataB = '0;
      repeat (3) tick();
      check("reset.dataOut", dataOut, 64'd0);
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.div_by_zero", 64'(div_by_zero), 64'd0);

      // DIVU held through reset must launch on the first edge after release
      Signal = DIVU; dataA = 32'd100; dataB = 32'd7;
      repeat (2) tick();
      check("reset_hold.busy", 64'(busy), 64'd0);
      reset = 1'b0;
      do_div(32'd100, 32'd7, 0, 0, 0, "div100_7");

      do_div(32'hFFFF_FFFF, 32'd1, 0, 1, 0, "b2b_max_1");
      do_div(32'd3, 32'd10, 0, 0, 0, "b2b_3_10");

      do_div(32'd5, 32'd0, 0, 0, 0, "div5_0");
      do_div(32'd9, 32'd3, 0, 0, 0, "div9_3");

      do_div(32'd50, 32'd8, 1, 0, 0, "held50_8");
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) nd++;
      end
      check("held.extra_done", 64'(nd), 64'd0);
      Signal = 6'd0;
      tick();

      do_div(32'd1234567, 32'd89, 0, 0, 10, "reraise");

      Signal = DIVU; dataA = 32'd77; dataB = 32'd5;
      tick();
      Signal = 6'd0;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      check("midreset.busy", 64'(busy), 64'd0);
      check("midreset.done", 64'(done), 64'd0);
      check("midreset.dataOut", dataOut, 64'd0);
      check("midreset.div_by_zero", 64'(div_by_zero), 64'd0);
      reset = 1'b0;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) nd++;
      end
      check("midreset.no_done", 64'(nd), 64'd0);
      do_div(32'd1000, 32'd33, 0, 0, 0, "div1000_33");

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 255));
            2:       rb = ra + 32'($urandom_range(0, 3));
            default: rb = $urandom;
         endcase
         do_div(ra, rb, 0, bit'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
      end
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
